// File: rtl/i2c_write_master.sv
// Single-master I2C write engine: one {slave addr, sub-addr, data} word per
// request, emitted as START, three bytes with ACK slots, STOP. END/ACK report
// completion and acknowledge status back to the requester.
module i2c_write_master #(
   parameter int CLK_FREQ = 27_000_000,
   parameter int I2C_FREQ = 20_000
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic [23:0] I2C_DATA,
   input  logic        START,
   output logic        END,
   output logic        ACK,
   output logic        I2C_SCL,
   inout  wire         I2C_SDA
);

   // Quarter-bit period in system clocks; must be at least 2.
   localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SA,    // bus idle-high lead-in
      ST_SB,    // SDA low while SCL high: START
      ST_BIT,   // one data bit per 4 quarters
      ST_ACK,   // slave acknowledge slot
      ST_PA,    // SCL low, SDA low
      ST_PB,    // SCL high, SDA low
      ST_PC     // SDA released while SCL high: STOP
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic [23:0]   shift_q, shift_d;
   logic          end_q, end_d;
   logic          ack_q, ack_d;
   logic          start_q;
   logic          sda_s1_q, sda_s2_q;
   logic          scl;
   logic          sda_oe;
   logic          quarter_done;

   // START edge register and 2-flop synchronizer for the SDA readback.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         start_q  <= 1'b0;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
      end else begin
         start_q  <= START;
         sda_s1_q <= I2C_SDA;
         sda_s2_q <= sda_s1_q;
      end
   end

   // Transaction state and counters.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         qtr_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         end_q   <= 1'b1;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         end_q   <= end_d;
         ack_q   <= ack_d;
      end
   end

   // Next-state logic and bus drive decode; every state step lasts one quarter.
   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      qtr_d        = qtr_q;
      bit_d        = bit_q;
      byte_d       = byte_q;
      shift_d      = shift_q;
      end_d        = end_q;
      ack_d        = ack_q;
      scl          = 1'b1;
      sda_oe       = 1'b0;
      quarter_done = (tick_q == TICK_MAX);

      if (state_q != ST_IDLE) begin
         tick_d = quarter_done ? '0 : tick_q + TW'(1);
      end

      case (state_q)
         ST_IDLE: begin
            // Only a fresh 0->1 edge starts a transfer; a held START does not.
            if (START && !start_q) begin
               shift_d = I2C_DATA;
               ack_d   = 1'b0;
               end_d   = 1'b0;
               tick_d  = '0;
               qtr_d   = '0;
               bit_d   = '0;
               byte_d  = '0;
               state_d = ST_SA;
            end
         end
         ST_SA: begin
            if (quarter_done) state_d = ST_SB;
         end
         ST_SB: begin
            sda_oe = 1'b1;
            if (quarter_done) state_d = ST_BIT;
         end
         ST_BIT: begin
            // SCL is low for quarters 0-1 and high for 2-3; SDA holds the MSB.
            scl    = qtr_q[1];
            sda_oe = ~shift_q[23];
            if (quarter_done) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  shift_d = {shift_q[22:0], 1'b0};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            scl = qtr_q[1];
            if (quarter_done) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  if (sda_s2_q) begin
                     ack_d   = 1'b1;
                     state_d = ST_PA;
                  end else if (byte_q != 2'd2) begin
                     byte_d  = byte_q + 2'd1;
                     state_d = ST_BIT;
                  end else begin
                     state_d = ST_PA;
                  end
               end
            end
         end
         ST_PA: begin
            scl    = 1'b0;
            sda_oe = 1'b1;
            if (quarter_done) state_d = ST_PB;
         end
         ST_PB: begin
            sda_oe = 1'b1;
            if (quarter_done) state_d = ST_PC;
         end
         ST_PC: begin
            if (quarter_done) begin
               end_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign I2C_SCL = scl;
   assign I2C_SDA = sda_oe ? 1'b0 : 1'bz;
   assign END     = end_q;
   assign ACK     = ack_q;

endmodule
